// File: rtl/nonce_dispatcher.sv
// Splits a nonce range across NUM_CORES hash cores and merges their finds
// (plus one range-exhausted marker) into a single buffered result stream.
module nonce_dispatcher #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_work,
  input  logic [31:0]               nonce_start,
  input  logic [31:0]               nonce_end,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [32*NUM_CORES-1:0]   core_nonce_start,
  output logic [32*NUM_CORES-1:0]   core_nonce_end,
  input  logic [NUM_CORES-1:0]      core_found,
  input  logic [32*NUM_CORES-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]      core_done,
  output logic [NUM_CORES-1:0]      core_ack,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic                      result_found,
  output logic [31:0]               result_data,
  output logic                      hashing,
  output logic                      overflow
);
  localparam int unsigned SHIFT = $clog2(NUM_CORES);
  localparam int unsigned CW    = (SHIFT > 0) ? SHIFT : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, LAUNCH, RUN} state_e;
  state_e state_q, state_d;

  logic [31:0]             start_q, end_q;
  logic [NUM_CORES-1:0]    active_q, active_d;
  logic [32*NUM_CORES-1:0] cstart_q, cstart_d, cend_q, cend_d;
  logic [NUM_CORES-1:0]    ack_q, gnt, req;
  logic [CW-1:0]           ptr_q, ptr_d;
  logic [31:0]             gnt_nonce_q, gnt_nonce;
  logic                    fin_q, complete, hashing_q, overflow_q;
  logic                    run, wr_en, pop, full, push, drop;
  logic [32:0]             wdata;
  logic [32:0]             span, slice_w;
  logic [31:0]             slice;
  logic [32:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]           rd_q, wr_q;
  logic [AW:0]             cnt_q;

  // Range partitioning; a span smaller than the core count goes entirely to core 0.
  always_comb begin
    span     = {1'b0, end_q - start_q} + 33'd1;
    slice_w  = span >> SHIFT;
    slice    = slice_w[31:0];
    cstart_d = '0;
    cend_d   = '0;
    active_d = '0;
    if (slice_w == '0) begin
      active_d[0]    = 1'b1;
      cstart_d[31:0] = start_q;
      cend_d[31:0]   = end_q;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        cstart_d[32*i +: 32] = start_q + slice * 32'(i);
        cend_d[32*i +: 32]   = start_q + slice * 32'(i) + slice - 32'd1;
      end
      active_d = '1;
      cend_d[32*(NUM_CORES-1) +: 32] = end_q;
    end
  end

  // Round-robin arbiter; a core acked last cycle still shows found, so it is masked.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    run       = (state_q == RUN);
    req       = core_found & active_q & ~ack_q & {NUM_CORES{run && !fin_q}};
    gnt       = '0;
    gnt_nonce = '0;
    ptr_d     = ptr_q;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      idx = (32'(ptr_q) + j) % NUM_CORES;
      if (gnt == '0 && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_nonce = core_nonce[32*idx +: 32];
        ptr_d     = CW'((idx + 1) % NUM_CORES);
      end
    end
    complete = run && !fin_q && ((core_done & active_q) == active_q) &&
               ((core_found & active_q) == '0) && (ack_q == '0);
  end

  always_comb begin
    wr_en = (ack_q != '0) || fin_q;
    wdata = fin_q ? {1'b0, end_q} : {1'b1, gnt_nonce_q};
    pop   = result_valid && result_ready;
    full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    push  = !new_work && wr_en && (!full || pop);
    drop  = !new_work && wr_en && full && !pop;
  end

  // fin_q keeps the FSM in RUN for the cycle that writes the exhausted entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      SETUP:   state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (fin_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (new_work) state_d = SETUP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      active_q    <= '0;
      cstart_q    <= '0;
      cend_q      <= '0;
      ack_q       <= '0;
      ptr_q       <= '0;
      gnt_nonce_q <= '0;
      fin_q       <= 1'b0;
      hashing_q   <= 1'b0;
      overflow_q  <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (new_work) begin
        start_q    <= nonce_start;
        end_q      <= nonce_end;
        hashing_q  <= 1'b1;
        overflow_q <= 1'b0;
        ack_q      <= '0;
        fin_q      <= 1'b0;
        ptr_q      <= '0;
        rd_q       <= '0;
        wr_q       <= '0;
        cnt_q      <= '0;
      end else begin
        if (state_q == SETUP) begin
          cstart_q <= cstart_d;
          cend_q   <= cend_d;
          active_q <= active_d;
        end
        ack_q <= gnt;
        if (gnt != '0) begin
          gnt_nonce_q <= gnt_nonce;
          ptr_q       <= ptr_d;
        end
        fin_q <= complete;
        if (complete) hashing_q <= 1'b0;
        if (drop) overflow_q <= 1'b1;
        if (push) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
        if (push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
        else if (!push && pop) cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign result_valid     = (cnt_q != '0);
  assign result_found     = result_valid & mem_q[rd_q][32];
  assign result_data      = result_valid ? mem_q[rd_q][31:0] : '0;
  assign core_start       = (state_q == LAUNCH) ? active_q : '0;
  assign core_ack         = run ? ack_q : '0;
  assign core_nonce_start = cstart_q;
  assign core_nonce_end   = cend_q;
  assign hashing          = hashing_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: the stimulus process queues expected
// start/ack/result/status events and the negedge monitor retires them.
module tb_nonce_dispatcher;
  localparam int unsigned NC = 4;
  localparam int unsigned FD = 4;

  logic              clk = 1'b0;
  logic              rst, new_work, result_ready;
  logic [31:0]       nonce_start, nonce_end;
  logic [NC-1:0]     core_start, core_found, core_done, core_ack;
  logic [32*NC-1:0]  core_nonce_start, core_nonce_end, core_nonce;
  logic              result_valid, result_found, hashing, overflow;
  logic [31:0]       result_data;

  always #5 clk = ~clk;

  nonce_dispatcher #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .new_work(new_work),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_start(core_start), .core_nonce_start(core_nonce_start),
    .core_nonce_end(core_nonce_end), .core_found(core_found),
    .core_nonce(core_nonce), .core_done(core_done), .core_ack(core_ack),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_found(result_found), .result_data(result_data),
    .hashing(hashing), .overflow(overflow)
  );

  typedef struct packed {
    logic [3:0]       mask;
    logic [3:0][31:0] s;
    logic [3:0][31:0] e;
  } start_t;
  typedef struct packed { logic found; logic [31:0] data; } res_t;
  typedef struct packed { logic zero_all; logic hash; logic ovf; logic valid; } lvl_t;

  start_t     exp_start_q[$];
  logic [3:0] exp_ack_q[$];
  res_t       exp_res_q[$];
  lvl_t       lvl_q[$];
  int         n_run = 0;
  int         n_fail = 0;
  logic       end_req = 1'b0;

  start_t     mst;
  res_t       mres;
  lvl_t       mlvl;
  logic [3:0] mack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_start != '0) begin
      if (exp_start_q.size() == 0) chk("unexpected_core_start", 64'(core_start), 64'(0));
      else begin
        mst = exp_start_q.pop_front();
        chk("core_start_mask", 64'(core_start), 64'(mst.mask));
        for (int i = 0; i < 4; i++)
          if (mst.mask[i])
            chk($sformatf("core%0d_range", i),
                {core_nonce_start[32*i +: 32], core_nonce_end[32*i +: 32]},
                {mst.s[i], mst.e[i]});
      end
    end
    if (core_ack != '0) begin
      if (exp_ack_q.size() == 0) chk("unexpected_core_ack", 64'(core_ack), 64'(0));
      else begin
        mack = exp_ack_q.pop_front();
        chk("core_ack", 64'(core_ack), 64'(mack));
      end
    end
    if (result_valid && result_ready) begin
      if (exp_res_q.size() == 0) chk("unexpected_result", {31'd0, result_found, result_data}, 64'(0));
      else begin
        mres = exp_res_q.pop_front();
        chk("result", {31'd0, result_found, result_data}, {31'd0, mres.found, mres.data});
      end
    end
    while (lvl_q.size() > 0) begin
      mlvl = lvl_q.pop_front();
      if (mlvl.zero_all)
        chk("all_outputs_zero",
            {51'd0, |core_nonce_start, |core_nonce_end, |result_data, core_start, core_ack,
             result_valid, result_found, hashing, overflow}, 64'(0));
      else
        chk("hashing_overflow_valid", {61'd0, hashing, overflow, result_valid},
            {61'd0, mlvl.hash, mlvl.ovf, mlvl.valid});
    end
    if (end_req) begin
      chk("leftover_expectations",
          64'(exp_start_q.size() + exp_ack_q.size() + exp_res_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  function automatic start_t mk_start(input logic [3:0] m,
      input logic [31:0] s0, e0, s1, e1, s2, e2, s3, e3);
    start_t x;
    x.mask = m;
    x.s[0] = s0; x.e[0] = e0;
    x.s[1] = s1; x.e[1] = e1;
    x.s[2] = s2; x.e[2] = e2;
    x.s[3] = s3; x.e[3] = e3;
    return x;
  endfunction

  function automatic lvl_t mk_lvl(input logic z, input logic h, input logic o, input logic v);
    lvl_t x;
    x.zero_all = z; x.hash = h; x.ovf = o; x.valid = v;
    return x;
  endfunction

  // Core model: a core drops found the cycle after its ack and clears done on start.
  task automatic step(input int n);
    logic [3:0] a, s;
    for (int k = 0; k < n; k++) begin
      a = core_ack;
      s = core_start;
      @(posedge clk);
      #1;
      core_found = core_found & ~a;
      core_done  = core_done & ~s;
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] e, input start_t x);
    nonce_start = s;
    nonce_end   = e;
    new_work    = 1'b1;
    exp_start_q.push_back(x);
    step(1);
    new_work = 1'b0;
    lvl_q.push_back(mk_lvl(1'b0, 1'b1, 1'b0, 1'b0));
    step(2);
  endtask

  task automatic finish_run(input logic [3:0] dmask, input logic [31:0] e, input logic ovf);
    res_t r;
    core_done = core_done | dmask;
    r.found = 1'b0;
    r.data  = e;
    exp_res_q.push_back(r);
    step(1);
    lvl_q.push_back(mk_lvl(1'b0, 1'b0, ovf, 1'b0));
    step(3);
  endtask

  task automatic exp_find(input logic [3:0] ack, input logic [31:0] nonce, input logic kept);
    res_t r;
    exp_ack_q.push_back(ack);
    r.found = 1'b1;
    r.data  = nonce;
    if (kept) exp_res_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; new_work = 1'b0; nonce_start = '0; nonce_end = '0;
    result_ready = 1'b1; core_found = '0; core_done = '0; core_nonce = '0;
    step(2);
    lvl_q.push_back(mk_lvl(1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    step(1);

    // Even split 0..3FF
    launch(32'h0, 32'h3FF, mk_start(4'b1111, 32'h000, 32'h0FF, 32'h100, 32'h1FF,
                                              32'h200, 32'h2FF, 32'h300, 32'h3FF));
    finish_run(4'b1111, 32'h3FF, 1'b0);

    // Wrapping range, span 0x200
    launch(32'hFFFFFF00, 32'h000000FF,
           mk_start(4'b1111, 32'hFFFFFF00, 32'hFFFFFF7F, 32'hFFFFFF80, 32'hFFFFFFFF,
                             32'h00000000, 32'h0000007F, 32'h00000080, 32'h000000FF));
    finish_run(4'b1111, 32'h000000FF, 1'b0);

    // Span 2 < 4 cores: only core 0
    launch(32'd5, 32'd6, mk_start(4'b0001, 32'd5, 32'd6, 0, 0, 0, 0, 0, 0));
    finish_run(4'b0001, 32'd6, 1'b0);

    // Simultaneous finds on cores 1,2,3
    launch(32'h0, 32'h3FF, mk_start(4'b1111, 32'h000, 32'h0FF, 32'h100, 32'h1FF,
                                              32'h200, 32'h2FF, 32'h300, 32'h3FF));
    core_nonce = {32'h33, 32'h22, 32'h11, 32'h0};
    core_found = 4'b1110;
    exp_find(4'b0010, 32'h11, 1'b1);
    exp_find(4'b0100, 32'h22, 1'b1);
    exp_find(4'b1000, 32'h33, 1'b1);
    step(6);
    finish_run(4'b1111, 32'h3FF, 1'b0);

    // Six finds with the consumer stalled: last two dropped, all acked
    result_ready = 1'b0;
    launch(32'h0, 32'h3FF, mk_start(4'b1111, 32'h000, 32'h0FF, 32'h100, 32'h1FF,
                                              32'h200, 32'h2FF, 32'h300, 32'h3FF));
    core_nonce = {32'hD0, 32'hC0, 32'hB0, 32'hA0};
    core_found = 4'b1111;
    exp_find(4'b0001, 32'hA0, 1'b1);
    exp_find(4'b0010, 32'hB0, 1'b1);
    exp_find(4'b0100, 32'hC0, 1'b1);
    exp_find(4'b1000, 32'hD0, 1'b1);
    step(6);
    core_nonce = {32'hD0, 32'hC0, 32'hF0, 32'hE0};
    core_found = 4'b0011;
    exp_find(4'b0001, 32'hE0, 1'b0);
    exp_find(4'b0010, 32'hF0, 1'b0);
    step(4);
    lvl_q.push_back(mk_lvl(1'b0, 1'b1, 1'b1, 1'b1));
    step(1);
    result_ready = 1'b1;
    step(6);
    finish_run(4'b1111, 32'h3FF, 1'b1);

    // new_work mid-RUN with two entries queued
    result_ready = 1'b0;
    launch(32'h0, 32'h3FF, mk_start(4'b1111, 32'h000, 32'h0FF, 32'h100, 32'h1FF,
                                              32'h200, 32'h2FF, 32'h300, 32'h3FF));
    core_nonce = {32'h0, 32'h0, 32'h2, 32'h1};
    core_found = 4'b0011;
    exp_find(4'b0001, 32'h1, 1'b0);
    exp_find(4'b0010, 32'h2, 1'b0);
    step(5);
    lvl_q.push_back(mk_lvl(1'b0, 1'b1, 1'b0, 1'b1));
    launch(32'h1000, 32'h13FF, mk_start(4'b1111, 32'h1000, 32'h10FF, 32'h1100, 32'h11FF,
                                                 32'h1200, 32'h12FF, 32'h1300, 32'h13FF));
    result_ready = 1'b1;
    finish_run(4'b1111, 32'h13FF, 1'b0);

    // rst mid-RUN, then rst together with new_work
    launch(32'h0, 32'h3FF, mk_start(4'b1111, 32'h000, 32'h0FF, 32'h100, 32'h1FF,
                                              32'h200, 32'h2FF, 32'h300, 32'h3FF));
    core_nonce = {32'h0, 32'h0, 32'h0, 32'h77};
    core_found = 4'b0001;
    rst = 1'b1;
    step(1);
    lvl_q.push_back(mk_lvl(1'b1, 1'b0, 1'b0, 1'b0));
    core_found = '0;
    new_work = 1'b1;
    step(1);
    lvl_q.push_back(mk_lvl(1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    new_work = 1'b0;
    step(3);
    lvl_q.push_back(mk_lvl(1'b1, 1'b0, 1'b0, 1'b0));
    step(1);
    end_req = 1'b1;
  end
endmodule
